// File: rtl/disp_colr_if.sv
// Display-side pixel bus into the colour-depth adapter and its aligned output.
// The master drives the disp_* timing, coordinates and colour. The slave returns the out_* signals.
interface disp_colr_if #(
   parameter int BPC_IN  = 5,
   parameter int BPC_OUT = 8,
   parameter int CORDW   = 16
);
   logic [1:0]              mode;
   logic signed [CORDW-1:0] disp_x;
   logic signed [CORDW-1:0] disp_y;
   logic                    disp_hsync;
   logic                    disp_vsync;
   logic                    disp_de;
   logic                    disp_frame;
   logic [BPC_IN-1:0]       disp_r;
   logic [BPC_IN-1:0]       disp_g;
   logic [BPC_IN-1:0]       disp_b;
   logic                    out_hsync;
   logic                    out_vsync;
   logic                    out_de;
   logic                    out_frame;
   logic [BPC_OUT-1:0]      out_r;
   logic [BPC_OUT-1:0]      out_g;
   logic [BPC_OUT-1:0]      out_b;

   modport master (
      output mode, disp_x, disp_y, disp_hsync, disp_vsync, disp_de, disp_frame,
             disp_r, disp_g, disp_b,
      input  out_hsync, out_vsync, out_de, out_frame, out_r, out_g, out_b
   );

   modport slave (
      input  mode, disp_x, disp_y, disp_hsync, disp_vsync, disp_de, disp_frame,
             disp_r, disp_g, disp_b,
      output out_hsync, out_vsync, out_de, out_frame, out_r, out_g, out_b
   );
endinterface

// File: rtl/disp_colr_adapt.sv
// Two-stage colour-depth adapter. It expands by MSB-first bit replication, or it reduces
// with optional 4x4 Bayer dithering. Dithering is either static or rotated once per frame.
module disp_colr_adapt #(
   parameter int BPC_IN  = 5,
   parameter int BPC_OUT = 8,
   parameter int CORDW   = 16
) (
   input  logic        clk_pix,
   input  logic        rst_pix,
   disp_colr_if.slave  bus
);
   localparam bit EXPAND = (BPC_OUT >= BPC_IN);
   localparam int D_SH   = EXPAND ? 1 : BPC_IN - BPC_OUT;
   localparam int TS_SH  = 4 - D_SH;
   localparam int MAXO   = (1 << BPC_OUT) - 1;
   localparam logic [3:0] BAYER [16] = '{4'd0, 4'd8, 4'd2, 4'd10, 4'd12, 4'd4, 4'd14, 4'd6,
                                        4'd3, 4'd11, 4'd1, 4'd9, 4'd15, 4'd7, 4'd13, 4'd5};

   if (!EXPAND && (BPC_IN - BPC_OUT > 4)) begin : g_bad_depth
      $error("disp_colr_adapt: depth reduction must be 1..4 bits");
   end

   function automatic logic [BPC_OUT-1:0] expand_c(input logic [BPC_IN-1:0] c);
      logic [BPC_OUT-1:0] res;
      for (int i = 0; i < BPC_OUT; i++) begin
         res[BPC_OUT-1-i] = c[BPC_IN-1-(i % BPC_IN)];
      end
      return res;
   endfunction

   // The extra sum bit absorbs the carry, so a bright pixel clamps instead of wrapping.
   function automatic logic [BPC_OUT-1:0] reduce_sat(input logic [BPC_IN-1:0] c,
                                                     input logic [3:0] ts);
      logic [BPC_IN:0] sum;
      logic [BPC_IN:0] shv;
      sum = {1'b0, c} + (BPC_IN+1)'(ts);
      shv = sum >> D_SH;
      if (shv > (BPC_IN+1)'(MAXO)) return BPC_OUT'(MAXO);
      return BPC_OUT'(shv);
   endfunction

   logic [1:0]         mode_q, mode_d, f_q, f_d;
   logic [1:0]         xi, yi;
   logic [BPC_IN-1:0]  r_p1_q, r_p1_d, g_p1_q, g_p1_d, b_p1_q, b_p1_d;
   logic [3:0]         ts_p1_q, ts_p1_d;
   logic [2:0]         sync_p1_q, sync_p1_d;
   logic               vld_p1_q, vld_p1_d;
   logic [BPC_OUT-1:0] r_p2_q, r_p2_d, g_p2_q, g_p2_d, b_p2_q, b_p2_d;
   logic [2:0]         sync_p2_q, sync_p2_d;
   logic               vld_p2_q, vld_p2_d;
   logic               unused_coord;

   assign unused_coord = ^{bus.disp_x[CORDW-1:2], bus.disp_y[CORDW-1:2]};

   always_comb begin
      mode_d = mode_q;
      f_d    = f_q;
      if (bus.disp_frame) begin
         mode_d = bus.mode;
         f_d    = f_q + 2'd1;
      end
      xi = bus.disp_x[1:0];
      yi = bus.disp_y[1:0];
      if (mode_q == 2'b10) begin
         xi = xi + f_q;
         yi = yi + f_q;
      end
      // Stage 1: capture colour, timing and the per-pixel threshold
      ts_p1_d   = (mode_q == 2'b00) ? 4'd0 : (BAYER[{yi, xi}] >> TS_SH);
      r_p1_d    = bus.disp_r;
      g_p1_d    = bus.disp_g;
      b_p1_d    = bus.disp_b;
      sync_p1_d = {bus.disp_hsync, bus.disp_vsync, bus.disp_frame};
      vld_p1_d  = bus.disp_de;
      // Stage 2: depth conversion and blanking
      sync_p2_d = sync_p1_q;
      vld_p2_d  = vld_p1_q;
      r_p2_d    = '0;
      g_p2_d    = '0;
      b_p2_d    = '0;
      if (vld_p1_q) begin
         r_p2_d = EXPAND ? expand_c(r_p1_q) : reduce_sat(r_p1_q, ts_p1_q);
         g_p2_d = EXPAND ? expand_c(g_p1_q) : reduce_sat(g_p1_q, ts_p1_q);
         b_p2_d = EXPAND ? expand_c(b_p1_q) : reduce_sat(b_p1_q, ts_p1_q);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         mode_q    <= '0;
         f_q       <= '0;
         r_p1_q    <= '0;
         g_p1_q    <= '0;
         b_p1_q    <= '0;
         ts_p1_q   <= '0;
         sync_p1_q <= '0;
         vld_p1_q  <= 1'b0;
         r_p2_q    <= '0;
         g_p2_q    <= '0;
         b_p2_q    <= '0;
         sync_p2_q <= '0;
         vld_p2_q  <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         f_q       <= f_d;
         r_p1_q    <= r_p1_d;
         g_p1_q    <= g_p1_d;
         b_p1_q    <= b_p1_d;
         ts_p1_q   <= ts_p1_d;
         sync_p1_q <= sync_p1_d;
         vld_p1_q  <= vld_p1_d;
         r_p2_q    <= r_p2_d;
         g_p2_q    <= g_p2_d;
         b_p2_q    <= b_p2_d;
         sync_p2_q <= sync_p2_d;
         vld_p2_q  <= vld_p2_d;
      end
   end

   assign bus.out_hsync = sync_p2_q[2];
   assign bus.out_vsync = sync_p2_q[1];
   assign bus.out_frame = sync_p2_q[0];
   assign bus.out_de    = vld_p2_q;
   assign bus.out_r     = r_p2_q;
   assign bus.out_g     = g_p2_q;
   assign bus.out_b     = b_p2_q;
endmodule

// File: tb/tb_disp_colr_adapt.sv
// Bench for disp_colr_adapt: an 8->5 reducing instance and a 5->8 expanding instance on one clock,
// checked by directed vectors and by a queue-style arithmetic model under random stimulus.
module tb_disp_colr_adapt;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [1:0]         in_mode;
   logic signed [15:0] in_x, in_y;
   logic               in_hs, in_vs, in_de, in_fr;
   logic [7:0]         in_rr, in_rg, in_rb;
   logic [4:0]         in_er, in_eg, in_eb;

   disp_colr_if #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16)) rif ();
   disp_colr_if #(.BPC_IN(5), .BPC_OUT(8), .CORDW(16)) eif ();

   assign rif.mode = in_mode;      assign eif.mode = in_mode;
   assign rif.disp_x = in_x;       assign eif.disp_x = in_x;
   assign rif.disp_y = in_y;       assign eif.disp_y = in_y;
   assign rif.disp_hsync = in_hs;  assign eif.disp_hsync = in_hs;
   assign rif.disp_vsync = in_vs;  assign eif.disp_vsync = in_vs;
   assign rif.disp_de = in_de;     assign eif.disp_de = in_de;
   assign rif.disp_frame = in_fr;  assign eif.disp_frame = in_fr;
   assign rif.disp_r = in_rr;      assign eif.disp_r = in_er;
   assign rif.disp_g = in_rg;      assign eif.disp_g = in_eg;
   assign rif.disp_b = in_rb;      assign eif.disp_b = in_eb;

   disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16)) u_red (
      .clk_pix(clk), .rst_pix(rst), .bus(rif.slave));
   disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CORDW(16)) u_exp (
      .clk_pix(clk), .rst_pix(rst), .bus(eif.slave));

   typedef struct packed {
      logic [3:0] tim;
      logic [4:0] rr, rg, rb;
      logic [7:0] er, eg, eb;
   } exp_t;

   typedef struct {
      bit         pre;
      logic [1:0] mode;
      int         x, y;
      bit         de;
      logic [7:0] r;
      logic [4:0] want;
   } vec_t;

   int   bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
   int   nchk = 0, nerr = 0;
   int   mdl_f = 0, mdl_mode = 0;
   exp_t p1 = '0, p2 = '0;
   vec_t tbl [8];

   function automatic int red_ch(int c);
      int m, xi, yi, v;
      if (!in_de) return 0;
      m = (mdl_mode == 3) ? 1 : mdl_mode;
      if (m == 0) return c / 8;
      xi = ((int'(in_x) & 3) + ((m == 2) ? mdl_f : 0)) % 4;
      yi = ((int'(in_y) & 3) + ((m == 2) ? mdl_f : 0)) % 4;
      v = (c + bay[yi][xi] / 2) / 8;
      return (v > 31) ? 31 : v;
   endfunction

   function automatic int exp_ch(int c);
      int acc, n;
      if (!in_de) return 0;
      acc = 0;
      n = 0;
      while (n < 8) begin
         acc = acc * 32 + c;
         n += 5;
      end
      return acc >> (n - 8);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      exp_t e;
      e.tim = {in_hs, in_vs, in_de, in_fr};
      e.rr = 5'(red_ch(int'(in_rr)));
      e.rg = 5'(red_ch(int'(in_rg)));
      e.rb = 5'(red_ch(int'(in_rb)));
      e.er = 8'(exp_ch(int'(in_er)));
      e.eg = 8'(exp_ch(int'(in_eg)));
      e.eb = 8'(exp_ch(int'(in_eb)));
      if (rst) begin
         p1 = '0; p2 = '0; mdl_f = 0; mdl_mode = 0;
      end else begin
         p2 = p1;
         p1 = e;
         if (in_fr) begin
            mdl_f = (mdl_f + 1) % 4;
            mdl_mode = int'(in_mode);
         end
      end
      @(posedge clk);
      #1;
      chk("model_red",
          32'({rif.out_hsync, rif.out_vsync, rif.out_de, rif.out_frame, rif.out_r, rif.out_g, rif.out_b}),
          32'({p2.tim, p2.rr, p2.rg, p2.rb}));
      chk("model_exp",
          32'({eif.out_hsync, eif.out_vsync, eif.out_de, eif.out_frame, eif.out_r, eif.out_g, eif.out_b}),
          32'({p2.tim, p2.er, p2.eg, p2.eb}));
   endtask

   task automatic idle();
      in_de = 1'b0;
      in_fr = 1'b0;
      tick();
   endtask

   // One pixel on all three reduced channels, then one idle cycle so it reaches the output.
   task automatic pix(input int x, input int y, input logic [7:0] c, input bit de, input bit fr);
      in_x = 16'(x); in_y = 16'(y);
      in_rr = c; in_rg = c; in_rb = c;
      in_de = de; in_fr = fr;
      tick();
      idle();
   endtask

   task automatic pulse(input logic [1:0] m);
      in_mode = m;
      in_fr = 1'b1;
      in_de = 1'b0;
      tick();
      in_fr = 1'b0;
   endtask

   initial begin
      logic [4:0] tseq [8];
      tseq = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0};
      tbl[0] = '{1'b1, 2'b01, 0, 0, 1'b1, 8'd4,   5'd0};
      tbl[1] = '{1'b0, 2'b01, 1, 0, 1'b1, 8'd4,   5'd1};
      tbl[2] = '{1'b0, 2'b01, 3, 3, 1'b1, 8'hFF,  5'h1F};
      tbl[3] = '{1'b0, 2'b01, 3, 3, 1'b0, 8'hFF,  5'h00};
      tbl[4] = '{1'b1, 2'b00, 0, 0, 1'b1, 8'd4,   5'd0};
      tbl[5] = '{1'b0, 2'b00, 1, 0, 1'b1, 8'd4,   5'd0};
      tbl[6] = '{1'b1, 2'b11, 1, 0, 1'b1, 8'd4,   5'd1};
      tbl[7] = '{1'b1, 2'b00, 2, 1, 1'b1, 8'd250, 5'd31};

      rst = 1'b1; in_mode = 2'b00; in_x = '0; in_y = '0;
      in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_fr = 1'b0;
      in_rr = '0; in_rg = '0; in_rb = '0; in_er = '0; in_eg = '0; in_eb = '0;
      tick();
      chk("reset_red_outs", 32'({rif.out_de, rif.out_frame, rif.out_r}), 32'd0);
      rst = 1'b0;
      idle();

      // Expansion 5->8 with sync alignment
      in_er = 5'h1F; in_eg = 5'h10; in_eb = 5'h00; in_de = 1'b1; in_hs = 1'b1;
      tick();
      in_hs = 1'b0;
      idle();
      chk("expand_rgb", 32'({eif.out_r, eif.out_g, eif.out_b}), 32'h00FF8400);
      chk("expand_hsync", 32'(eif.out_hsync), 32'd1);
      idle();
      chk("expand_hsync_fall", 32'(eif.out_hsync), 32'd0);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].pre) pulse(tbl[i].mode);
         pix(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].de, 1'b0);
         chk($sformatf("tbl%0d_rgb", i), 32'({rif.out_r, rif.out_g, rif.out_b}),
             32'({tbl[i].want, tbl[i].want, tbl[i].want}));
      end

      // Mode request mid-frame stays inactive until the next frame pulse
      in_mode = 2'b01;
      pix(1, 0, 8'd4, 1'b1, 1'b0);
      chk("latch_midframe", 32'(rif.out_r), 32'd0);
      pix(1, 0, 8'd4, 1'b1, 1'b1);
      chk("latch_pulse_pixel", 32'(rif.out_r), 32'd0);
      pix(1, 0, 8'd4, 1'b1, 1'b0);
      chk("latch_after_pulse", 32'(rif.out_r), 32'd1);

      // Temporal dither across eight frames
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         pulse(2'b10);
         pix(0, 0, (k < 4) ? 8'd4 : 8'd6, 1'b1, 1'b0);
         chk($sformatf("temporal_%0d", k), 32'(rif.out_r), 32'(tseq[k]));
      end

      // Reset in mid-line, then release
      in_de = 1'b1; in_rr = 8'hFF; in_hs = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("midline_reset", 32'({rif.out_hsync, rif.out_de, rif.out_r}), 32'd0);
      rst = 1'b0;
      tick();
      chk("release_edge1", 32'({rif.out_de, rif.out_r}), 32'd0);
      tick();
      chk("release_edge2", 32'({rif.out_de, rif.out_r}), 32'({1'b1, 5'd31}));
      in_de = 1'b0;
      tick(); tick();
      chk("blank_ff", 32'({rif.out_de, rif.out_r}), 32'd0);
      in_hs = 1'b0;

      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         in_mode = 2'($urandom);
         in_x = 16'($urandom); in_y = 16'($urandom);
         in_hs = 1'($urandom); in_vs = 1'($urandom);
         in_de = ($urandom_range(0, 3) != 0);
         in_fr = ($urandom_range(0, 11) == 0);
         in_rr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         in_rg = 8'($urandom); in_rb = 8'($urandom);
         in_er = 5'($urandom); in_eg = 5'($urandom); in_eb = 5'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/disp_colr_adapt.md
# disp_colr_adapt

Parametrised colour-depth adapter between the display pipeline (`disp_*` signals) and the TMDS/board output stage. It replaces the fixed combinational 5→8-bit replication with a 2-stage pipeline that works for any input and output depth. When reducing depth it can apply ordered 4×4 Bayer dithering, either static or rotated per frame. Sync, data-enable and frame signals are delayed with the colour so all outputs stay aligned.

## Interface
- `BPC_IN`, 5: input bits per colour channel.
- `BPC_OUT`, 8: output bits per colour channel.
- `CORDW`, 16: signed coordinate width of `disp_x`/`disp_y`; only bits [1:0] are used.
- `clk_pix`  in  1  pixel clock; the only clock.
- `rst_pix`  in  1  reset, synchronous, active-high.
- `mode`  in  2  requested mode: 00 plain, 01 static dither, 10 temporal dither, 11 treated as 01.
- `disp_x`, `disp_y`  in  CORDW  current pixel coordinates.
- `disp_hsync`, `disp_vsync`, `disp_de`, `disp_frame`  in  1  timing inputs; `disp_frame` is a 1-cycle start-of-frame pulse.
- `disp_r`, `disp_g`, `disp_b`  in  BPC_IN  input colour.
- `out_hsync`, `out_vsync`, `out_de`, `out_frame`  out  1  timing signals delayed by 2 cycles.
- `out_r`, `out_g`, `out_b`  out  BPC_OUT  adapted colour.

## Operation
- Expansion (`BPC_OUT >= BPC_IN`):
  - Each output is the input replicated MSB-first until `BPC_OUT` bits are filled. For 5→8 this is `{c, c[4:2]}`.
  - `mode` is ignored.
- Reduction (`BPC_OUT < BPC_IN`):
  - Let D = `BPC_IN` − `BPC_OUT`. D must satisfy 1 ≤ D ≤ 4; any other value is an elaboration error.
  - Plain mode: out = c >> D.
  - Dither modes:
    - Threshold t = B[yi][xi], with Bayer rows: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
    - Scaled threshold ts = t >> (4−D).
    - sum = c + ts, computed at `BPC_IN`+1 bits.
    - out = min(sum >> D, 2^`BPC_OUT` − 1). Saturation is mandatory; wrap-around is forbidden.
  - Indices: static mode uses xi = x[1:0], yi = y[1:0]. Temporal mode uses xi = x[1:0] + f, yi = y[1:0] + f, both mod 4, where f is the 2-bit frame counter.
- Frame counter f:
  - Increments (wrapping 3→0) on every cycle where `disp_frame` = 1.
  - Resets to 0.
- Active mode register:
  - Resets to 00 (plain).
  - Loads `mode` only on cycles where `disp_frame` = 1. Mode changes never take effect mid-frame.
  - The new mode and f apply to pixels sampled from the cycle after the `disp_frame` cycle.
- Blanking: when the delayed `de` is 0, `out_r`/`out_g`/`out_b` are 0, regardless of input colour.
- All three channels use the same threshold for a given pixel.

## Timing
- Stage 1 registers colour, timing, threshold and mode. Stage 2 computes add/saturate/shift and registers all outputs.
- Latency: exactly 2 `clk_pix` cycles for every output, colour and timing alike. A new pixel can enter every cycle; there is no stall.
- Reset:
  - At the first clock edge with `rst_pix` = 1, every output becomes 0, both pipeline stages clear, f = 0 and the active mode = 00.
  - This also applies when reset is asserted mid-frame.
  - After `rst_pix` falls, outputs reflect input data from the 2nd edge onward. Until then they hold 0.
- Simultaneous events:
  - If `disp_frame` = 1 and `rst_pix` = 1 on the same edge, reset wins: f = 0, mode = 00.
  - `mode` changing on the same cycle as `disp_frame` is captured.

## Test plan
1. Expansion, BPC_IN=5, BPC_OUT=8, de=1: input r=5'h1F, g=5'h10, b=5'h00 → 2 cycles later `out_r`=8'hFF, `out_g`=8'h84, `out_b`=8'h00. Syncs track the input syncs with a 2-cycle lag.
2. Static dither, BPC_IN=8, BPC_OUT=5, mode=01 latched by a `disp_frame` pulse, r=8'd4:
   - x=0, y=0 (t=0) → `out_r`=0.
   - x=1, y=0 (t=8, ts=4) → `out_r`=1.
   - In plain mode (00), both pixels → 0.
3. Saturation, 8→5, dither on, r=8'hFF at x=3, y=3 (t=5, ts=2) → `out_r`=5'h1F; no wrap to 0.
4. Mode latching: set mode=01 mid-frame → output stays plain until the next `disp_frame`. Pixels entering after that pulse are dithered.
5. Temporal dither, mode=10, 8→5, r=8'd4 at x=0, y=0 → over 4 successive frames (f=1,2,3,0), t = 4, 1, 5, 0 and `out_r` = 0, 0, 0, 0. Then r=8'd6 gives `out_r` = 1, 0, 1, 0 across the same 4 frames.
6. Reset and blanking:
   - Assert `rst_pix` mid-line → all outputs 0 at the next edge. Release → first valid output at the 2nd edge after release.
   - de=0 with r=8'hFF → `out_r`=0.
